// File: rtl/fir_xifu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_xifu_pkg
// Description : Shared types and defaults for the FIR X-interface execute unit:
//               opcode enum, default sizing, ID->EX and EX->WB bundles, and
//               the Q15 output saturation helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_xifu_pkg;

  localparam int unsigned NTAPS_DEF     = 8;
  localparam int unsigned ACC_W_DEF     = 40;
  localparam int unsigned SHIFT_DEF     = 15;
  // Widest tap index the struct carries (NTAPS is at most 16).
  localparam int unsigned TAP_IDX_MAX_W = 4;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_LDTAP = 2'd1,
    OP_LDSAM = 2'd2,
    OP_STSAM = 2'd3
  } fir_op_e;

  typedef struct packed {
    logic                     valid;
    fir_op_e                  op;
    logic [3:0]               instr_id;
    logic [31:0]              rs1;
    logic [TAP_IDX_MAX_W-1:0] tap_idx;
    logic [4:0]               rd;
  } fir_xifu_id2ex_t;

  typedef struct packed {
    logic        valid;
    logic [3:0]  id;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
  } fir_xifu_ex2wb_t;

  // Clamp a signed value to the signed 16-bit range, returned sign-extended
  // to 32 bits. Callers sign-extend their operand to 64 bits first.
  function automatic logic [31:0] sat16(input logic signed [63:0] v);
    logic [31:0] r;
    if (v > 64'sd32767)       r = 32'h0000_7FFF;
    else if (v < -64'sd32768) r = 32'hFFFF_8000;
    else                      r = v[31:0];
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_xifu_mac.sv
`default_nettype none
// ============================================================================
// Module      : fir_xifu_mac
// Description : Combinational multiply-accumulate step: signed 16x16 product,
//               sign-extended to ACC_W and added to the running partial sum.
//               Sum wraps at ACC_W bits. Requires ACC_W > 32.
// Ports       : tap_i  - signed Q15 coefficient
//               x_i    - signed Q15 sample
//               psum_i - incoming partial sum
//               sum_o  - psum_i + sext(tap_i * x_i)
// Revision    : 1.0 - initial release
// ============================================================================
module fir_xifu_mac #(
  parameter int unsigned ACC_W = 40
) (
  input  logic signed [15:0]      tap_i,
  input  logic signed [15:0]      x_i,
  input  logic        [ACC_W-1:0] psum_i,
  output logic        [ACC_W-1:0] sum_o
);

  logic signed [31:0]      w_prod;
  logic        [ACC_W-1:0] w_prod_ext;

  assign w_prod     = tap_i * x_i;
  assign w_prod_ext = {{(ACC_W-32){w_prod[31]}}, w_prod};
  assign sum_o      = psum_i + w_prod_ext;

endmodule
`default_nettype wire

// File: rtl/fir_xifu_ex.sv
`default_nettype none
// ============================================================================
// Module      : fir_xifu_ex
// Description : Execute stage of the FIR X-interface unit. Holds the tap
//               bank, sample delay line and accumulator; runs one MAC per
//               cycle over NTAPS terms for LDSAM, writes taps for LDTAP and
//               returns the saturated Q15 result for STSAM.
// Ports       : clk_i/rst_ni        - clock, async active-low reset
//               id_*                - instruction handshake from ID
//               kill_i/kill_id_i    - controller kill of an in-flight MAC
//               wb_*                - result handshake towards writeback
//               busy_o              - unit not idle
// Revision    : 1.0 - initial release
// ============================================================================
module fir_xifu_ex
  import fir_xifu_pkg::*;
#(
  parameter int unsigned NTAPS = NTAPS_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned SHIFT = SHIFT_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     id_valid_i,
  output logic                     id_ready_o,
  input  logic [1:0]               id_op_i,
  input  logic [3:0]               id_instr_id_i,
  input  logic [31:0]              id_rs1_i,
  input  logic [$clog2(NTAPS)-1:0] id_tap_idx_i,
  input  logic [4:0]               id_rd_i,
  input  logic                     kill_i,
  input  logic [3:0]               kill_id_i,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [3:0]               wb_id_o,
  output logic [4:0]               wb_rd_o,
  output logic [31:0]              wb_data_o,
  output logic                     wb_we_o,
  output logic                     busy_o
);

  localparam int unsigned IDX_W = $clog2(NTAPS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                  r_state, w_state_nx;
  logic [IDX_W-1:0]        r_k;
  logic signed [15:0]      r_tap   [NTAPS];
  logic signed [15:0]      r_dl    [NTAPS-1];
  logic signed [15:0]      r_stage;
  logic [ACC_W-1:0]        r_acc;
  logic [ACC_W-1:0]        r_psum;
  logic [3:0]              r_id;
  fir_xifu_ex2wb_t         r_resp;

  fir_op_e                 w_op;
  logic                    w_accept;
  logic                    w_last;
  logic                    w_kill;
  logic signed [15:0]      w_xvec  [NTAPS];
  logic [ACC_W-1:0]        w_psum_in;
  logic [ACC_W-1:0]        w_sum;
  logic signed [ACC_W-1:0] w_acc_sh;
  logic signed [63:0]      w_acc_sh64;
  logic [31:0]             w_sat;
  logic                    w_unused_rs1_hi;

  assign w_op            = fir_op_e'(id_op_i);
  assign id_ready_o      = (r_state == S_IDLE);
  assign busy_o          = (r_state != S_IDLE);
  assign w_accept        = id_valid_i && id_ready_o;
  assign w_last          = (r_k == IDX_W'(NTAPS - 1));
  // A kill only matters while a sample is being filtered and only for its id.
  assign w_kill          = (r_state == S_MAC) && kill_i && (kill_id_i == r_id);
  assign w_unused_rs1_hi = ^id_rs1_i[31:16];

  // Term k uses the staged sample for k=0 and the delay line thereafter.
  assign w_xvec[0] = r_stage;
  for (genvar gi = 1; gi < NTAPS; gi++) begin : g_xvec
    assign w_xvec[gi] = r_dl[gi-1];
  end

  // k=0 starts a fresh sum so a stale partial never leaks into a new sample.
  assign w_psum_in = (r_k == '0) ? '0 : r_psum;

  fir_xifu_mac #(
    .ACC_W (ACC_W)
  ) u_mac (
    .tap_i  (r_tap[r_k]),
    .x_i    (w_xvec[r_k]),
    .psum_i (w_psum_in),
    .sum_o  (w_sum)
  );

  assign w_acc_sh   = $signed(r_acc) >>> SHIFT;
  assign w_acc_sh64 = {{(64-ACC_W){w_acc_sh[ACC_W-1]}}, w_acc_sh};
  assign w_sat      = sat16(w_acc_sh64);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          unique case (w_op)
            OP_LDTAP, OP_STSAM: w_state_nx = S_RESP;
            OP_LDSAM:           w_state_nx = S_MAC;
            default:            w_state_nx = S_IDLE;
          endcase
        end
      end
      S_MAC: begin
        if (w_kill)      w_state_nx = S_IDLE;
        else if (w_last) w_state_nx = S_RESP;
      end
      S_RESP: begin
        if (wb_ready_i) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_k     <= '0;
      r_stage <= '0;
      r_acc   <= '0;
      r_psum  <= '0;
      r_id    <= '0;
      r_resp  <= '0;
      for (int i = 0; i < NTAPS; i++)     r_tap[i] <= '0;
      for (int i = 0; i < NTAPS - 1; i++) r_dl[i]  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_id <= id_instr_id_i;
            unique case (w_op)
              OP_LDTAP: begin
                r_tap[id_tap_idx_i] <= id_rs1_i[15:0];
                r_resp <= '{valid: 1'b1, id: id_instr_id_i, rd: 5'd0,
                            data: 32'd0, we: 1'b0};
              end
              OP_LDSAM: begin
                r_stage <= id_rs1_i[15:0];
                r_k     <= '0;
              end
              OP_STSAM: begin
                r_resp <= '{valid: 1'b1, id: id_instr_id_i, rd: id_rd_i,
                            data: w_sat, we: 1'b1};
              end
              default: ;
            endcase
          end
        end
        S_MAC: begin
          if (w_kill) begin
            r_k     <= '0;
            r_stage <= '0;
          end else begin
            r_psum <= w_sum;
            if (w_last) begin
              r_acc   <= w_sum;
              r_k     <= '0;
              r_dl[0] <= r_stage;
              for (int i = 1; i < NTAPS - 1; i++) r_dl[i] <= r_dl[i-1];
              r_resp  <= '{valid: 1'b1, id: r_id, rd: 5'd0,
                           data: 32'd0, we: 1'b0};
            end else begin
              r_k <= r_k + 1'b1;
            end
          end
        end
        S_RESP: begin
          if (wb_ready_i) r_resp.valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign wb_valid_o = r_resp.valid;
  assign wb_id_o    = r_resp.id;
  assign wb_rd_o    = r_resp.rd;
  assign wb_data_o  = r_resp.data;
  assign wb_we_o    = r_resp.we;

endmodule
`default_nettype wire

// File: tb/tb_fir_xifu_ex.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_xifu_ex
// Description : Self-checking bench for fir_xifu_ex against a FIR reference
//               model (tap array, sample history, 40-bit wrapping sum).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_xifu_ex;
  import fir_xifu_pkg::*;

  localparam int NT = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        id_valid_i = 1'b0;
  logic        id_ready_o;
  logic [1:0]  id_op_i = 2'd0;
  logic [3:0]  id_instr_id_i = 4'd0;
  logic [31:0] id_rs1_i = 32'd0;
  logic [2:0]  id_tap_idx_i = 3'd0;
  logic [4:0]  id_rd_i = 5'd0;
  logic        kill_i = 1'b0;
  logic [3:0]  kill_id_i = 4'd0;
  logic        wb_valid_o;
  logic        wb_ready_i = 1'b1;
  logic [3:0]  wb_id_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        wb_we_o;
  logic        busy_o;

  int n_checks = 0;
  int n_errors = 0;
  int n_xfer   = 0;

  fir_xifu_ex #(.NTAPS(NT), .ACC_W(40), .SHIFT(15)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o), .id_op_i(id_op_i),
    .id_instr_id_i(id_instr_id_i), .id_rs1_i(id_rs1_i),
    .id_tap_idx_i(id_tap_idx_i), .id_rd_i(id_rd_i),
    .kill_i(kill_i), .kill_id_i(kill_id_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_id_o(wb_id_o),
    .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .wb_we_o(wb_we_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) if (wb_valid_o && wb_ready_i) n_xfer++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int     m_tap  [NT];
  int     m_hist [NT];   // m_hist[0] = most recent completed sample
  longint m_acc;

  function automatic void model_reset();
    for (int i = 0; i < NT; i++) begin m_tap[i] = 0; m_hist[i] = 0; end
    m_acc = 0;
  endfunction

  function automatic longint wrap40(input longint v);
    longint m;
    m = v & 64'h0000_00FF_FFFF_FFFF;
    if (m[39]) m = m - (64'sd1 <<< 40);
    return m;
  endfunction

  function automatic void model_ldsam(input int s);
    longint sum;
    sum = longint'(m_tap[0]) * s;
    for (int i = 1; i < NT; i++) sum += longint'(m_tap[i]) * m_hist[i-1];
    m_acc = wrap40(sum);
    for (int i = NT - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = s;
  endfunction

  function automatic logic [31:0] model_stsam();
    longint sh;
    sh = m_acc >>> 15;
    if (sh > 32767)  return 32'h0000_7FFF;
    if (sh < -32768) return 32'hFFFF_8000;
    return 32'(sh);
  endfunction

  function automatic int s16(input logic [31:0] v);
    shortint t;
    t = v[15:0];
    return int'(t);
  endfunction

  // ---------------- drivers ----------------
  task automatic issue(input fir_op_e op, input logic [3:0] id,
                       input logic [31:0] rs1, input logic [2:0] idx,
                       input logic [4:0] rd);
    int n;
    n = 0;
    while (!id_ready_o && n < 50) begin @(posedge clk_i); #1; n++; end
    if (!id_ready_o) begin
      n_checks++; n_errors++;
      $display("FAIL issue_ready_timeout: id_ready_o=%0b, required 1", id_ready_o);
    end
    id_valid_i = 1'b1; id_op_i = op; id_instr_id_i = id;
    id_rs1_i = rs1; id_tap_idx_i = idx; id_rd_i = rd;
    @(posedge clk_i); #1;
    id_valid_i = 1'b0; id_op_i = OP_NOP;
  endtask

  task automatic get_resp(output int lat, output logic [3:0] id,
                          output logic [4:0] rd, output logic [31:0] data,
                          output logic we);
    lat = 0;
    while (!wb_valid_o && lat < 100) begin @(posedge clk_i); #1; lat++; end
    if (!wb_valid_o) begin
      n_checks++; n_errors++;
      $display("FAIL resp_timeout: wb_valid_o=%0b after %0d cycles, required 1", wb_valid_o, lat);
    end
    id = wb_id_o; rd = wb_rd_o; data = wb_data_o; we = wb_we_o;
    @(posedge clk_i); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    n_checks++;
    if ({wb_valid_o, wb_we_o, wb_id_o, wb_rd_o, wb_data_o, busy_o, id_ready_o} !== {1'b0, 1'b0, 4'd0, 5'd0, 32'd0, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL reset_outputs: valid=%0b we=%0b id=%0h rd=%0h data=%08h busy=%0b ready=%0b, required 0 0 0 0 00000000 0 1",
               wb_valid_o, wb_we_o, wb_id_o, wb_rd_o, wb_data_o, busy_o, id_ready_o);
    end
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    model_reset();
  endtask

  task automatic test_tap_output();
    int lat; logic [3:0] id; logic [4:0] rd; logic [31:0] d; logic we;
    issue(OP_LDTAP, 4'd1, 32'h0000_4000, 3'd0, 5'd0);
    m_tap[0] = s16(32'h4000);
    get_resp(lat, id, rd, d, we);
    n_checks++;
    if (lat !== 0 || id !== 4'd1 || we !== 1'b0 || d !== 32'd0) begin
      n_errors++;
      $display("FAIL ldtap_resp: lat=%0d id=%0h we=%0b data=%08h, required 0 1 0 00000000", lat, id, we, d);
    end
    issue(OP_LDSAM, 4'd2, 32'h0000_0100, 3'd0, 5'd0);
    model_ldsam(s16(32'h0100));
    get_resp(lat, id, rd, d, we);
    n_checks++;
    if (lat !== NT || id !== 4'd2 || we !== 1'b0) begin
      n_errors++;
      $display("FAIL ldsam_latency: lat=%0d id=%0h we=%0b, required %0d 2 0", lat, id, we, NT);
    end
    issue(OP_STSAM, 4'd3, 32'd0, 3'd0, 5'd5);
    get_resp(lat, id, rd, d, we);
    n_checks++;
    if (d !== 32'h0000_0080 || we !== 1'b1 || rd !== 5'd5 || id !== 4'd3) begin
      n_errors++;
      $display("FAIL stsam_basic: data=%08h we=%0b rd=%0d id=%0h, required 00000080 1 5 3", d, we, rd, id);
    end
    n_checks++;
    if (d !== model_stsam()) begin
      n_errors++;
      $display("FAIL stsam_basic_model: data=%08h, required %08h", d, model_stsam());
    end
  endtask

  task automatic test_kill();
    int lat; logic [3:0] id; logic [4:0] rd; logic [31:0] d; logic we;
    int x0;
    x0 = n_xfer;
    issue(OP_LDSAM, 4'd4, 32'h0000_1000, 3'd0, 5'd0);
    repeat (3) begin @(posedge clk_i); #1; end   // now at k=3
    kill_i = 1'b1; kill_id_i = 4'd4;
    @(posedge clk_i); #1;
    kill_i = 1'b0;
    n_checks++;
    if (busy_o !== 1'b0 || wb_valid_o !== 1'b0 || id_ready_o !== 1'b1) begin
      n_errors++;
      $display("FAIL kill_idle: busy=%0b valid=%0b ready=%0b, required 0 0 1", busy_o, wb_valid_o, id_ready_o);
    end
    repeat (12) begin @(posedge clk_i); #1; end
    n_checks++;
    if (n_xfer - x0 !== 0) begin
      n_errors++;
      $display("FAIL kill_no_resp: transfers=%0d, required 0", n_xfer - x0);
    end
    issue(OP_STSAM, 4'd5, 32'd0, 3'd0, 5'd7);
    get_resp(lat, id, rd, d, we);
    n_checks++;
    if (d !== 32'h0000_0080 || d !== model_stsam() || rd !== 5'd7) begin
      n_errors++;
      $display("FAIL kill_acc_kept: data=%08h rd=%0d, required 00000080 7", d, rd);
    end
  endtask

  task automatic test_kill_mismatch();
    int lat; logic [3:0] id; logic [4:0] rd; logic [31:0] d; logic we;
    logic [31:0] s;
    s = $urandom;
    kill_i = 1'b1; kill_id_i = 4'd9;   // wrong id held through the whole MAC
    issue(OP_LDSAM, 4'd6, s, 3'd0, 5'd0);
    model_ldsam(s16(s));
    get_resp(lat, id, rd, d, we);
    kill_i = 1'b0;
    n_checks++;
    if (lat !== NT || id !== 4'd6) begin
      n_errors++;
      $display("FAIL kill_mismatch: lat=%0d id=%0h, required %0d 6", lat, id, NT);
    end
    issue(OP_STSAM, 4'd7, 32'd0, 3'd0, 5'd1);
    get_resp(lat, id, rd, d, we);
    n_checks++;
    if (d !== model_stsam()) begin
      n_errors++;
      $display("FAIL kill_mismatch_acc: data=%08h, required %08h", d, model_stsam());
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d0; logic [4:0] r0; logic [3:0] i0;
    int x0; int bad;
    bad = 0;
    wb_ready_i = 1'b0;
    issue(OP_STSAM, 4'd10, 32'd0, 3'd0, 5'd9);
    x0 = n_xfer;
    d0 = wb_data_o; r0 = wb_rd_o; i0 = wb_id_o;
    n_checks++;
    if (wb_valid_o !== 1'b1 || d0 !== model_stsam() || r0 !== 5'd9 || i0 !== 4'd10) begin
      n_errors++;
      $display("FAIL bp_first: valid=%0b data=%08h rd=%0d id=%0h, required 1 %08h 9 a", wb_valid_o, d0, r0, i0, model_stsam());
    end
    kill_i = 1'b1; kill_id_i = 4'd10;   // matching kill in RESP must be ignored
    repeat (5) begin
      @(posedge clk_i); #1;
      if (wb_valid_o !== 1'b1 || id_ready_o !== 1'b0 || wb_data_o !== d0 ||
          wb_rd_o !== r0 || wb_id_o !== i0 || wb_we_o !== 1'b1) bad++;
    end
    kill_i = 1'b0;
    n_checks++;
    if (bad !== 0) begin
      n_errors++;
      $display("FAIL bp_hold: unstable cycles=%0d, required 0", bad);
    end
    wb_ready_i = 1'b1;
    @(posedge clk_i); #1;
    repeat (3) begin @(posedge clk_i); #1; end
    n_checks++;
    if (n_xfer - x0 !== 1 || wb_valid_o !== 1'b0 || id_ready_o !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_single_xfer: transfers=%0d valid=%0b ready=%0b, required 1 0 1", n_xfer - x0, wb_valid_o, id_ready_o);
    end
  endtask

  task automatic test_saturation();
    int lat; logic [3:0] id; logic [4:0] rd; logic [31:0] d; logic we;
    for (int i = 0; i < NT; i++) begin
      issue(OP_LDTAP, 4'd11, 32'h0000_7FFF, 3'(i), 5'd0);
      m_tap[i] = 32767;
      get_resp(lat, id, rd, d, we);
    end
    for (int i = 0; i < NT; i++) begin
      issue(OP_LDSAM, 4'd12, 32'h0000_7FFF, 3'd0, 5'd0);
      model_ldsam(32767);
      get_resp(lat, id, rd, d, we);
    end
    issue(OP_STSAM, 4'd13, 32'd0, 3'd0, 5'd2);
    get_resp(lat, id, rd, d, we);
    n_checks++;
    if (d !== 32'h0000_7FFF || d !== model_stsam()) begin
      n_errors++;
      $display("FAIL sat_pos: data=%08h, required 00007fff", d);
    end
    for (int i = 0; i < NT; i++) begin
      issue(OP_LDSAM, 4'd12, 32'h0000_8000, 3'd0, 5'd0);
      model_ldsam(-32768);
      get_resp(lat, id, rd, d, we);
    end
    issue(OP_STSAM, 4'd14, 32'd0, 3'd0, 5'd3);
    get_resp(lat, id, rd, d, we);
    n_checks++;
    if (d !== 32'hFFFF_8000 || d !== model_stsam()) begin
      n_errors++;
      $display("FAIL sat_neg: data=%08h, required ffff8000", d);
    end
  endtask

  task automatic test_random();
    int lat; logic [3:0] id; logic [4:0] rd; logic [31:0] d; logic we;
    int unsigned sel; logic [3:0] rid; logic [31:0] rs; logic [2:0] ridx;
    logic [4:0] rrd; logic [31:0] exp;
    for (int it = 0; it < 60; it++) begin
      sel  = $urandom_range(0, 3);
      rid  = 4'($urandom);
      rs   = $urandom;
      ridx = 3'($urandom);
      rrd  = 5'($urandom);
      case (sel)
        0: begin
          issue(OP_NOP, rid, rs, ridx, rrd);
          repeat (2) begin @(posedge clk_i); #1; end
          n_checks++;
          if (busy_o !== 1'b0 || wb_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL rnd_nop: busy=%0b valid=%0b, required 0 0", busy_o, wb_valid_o);
          end
        end
        1: begin
          issue(OP_LDTAP, rid, rs, ridx, rrd);
          m_tap[ridx] = s16(rs);
          get_resp(lat, id, rd, d, we);
          n_checks++;
          if (lat !== 0 || id !== rid || we !== 1'b0 || d !== 32'd0) begin
            n_errors++;
            $display("FAIL rnd_ldtap: lat=%0d id=%0h we=%0b data=%08h, required 0 %0h 0 00000000", lat, id, we, d, rid);
          end
        end
        2: begin
          issue(OP_LDSAM, rid, rs, ridx, rrd);
          model_ldsam(s16(rs));
          get_resp(lat, id, rd, d, we);
          n_checks++;
          if (lat !== NT || id !== rid || we !== 1'b0) begin
            n_errors++;
            $display("FAIL rnd_ldsam: lat=%0d id=%0h we=%0b, required %0d %0h 0", lat, id, we, NT, rid);
          end
        end
        default: begin
          exp = model_stsam();
          issue(OP_STSAM, rid, rs, ridx, rrd);
          get_resp(lat, id, rd, d, we);
          n_checks++;
          if (d !== exp || we !== 1'b1 || rd !== rrd || id !== rid || lat !== 0) begin
            n_errors++;
            $display("FAIL rnd_stsam: data=%08h we=%0b rd=%0d id=%0h lat=%0d, required %08h 1 %0d %0h 0", d, we, rd, id, lat, exp, rrd, rid);
          end
        end
      endcase
    end
  endtask

  task automatic test_reset_mid_mac();
    int lat; logic [3:0] id; logic [4:0] rd; logic [31:0] d; logic we;
    // Leave non-zero response registers behind so the reset clear is visible.
    issue(OP_STSAM, 4'hF, 32'd0, 3'd0, 5'd31);
    get_resp(lat, id, rd, d, we);
    issue(OP_LDSAM, 4'd8, 32'h0000_1234, 3'd0, 5'd0);
    repeat (3) begin @(posedge clk_i); #1; end
    rst_ni = 1'b0;
    #2;
    n_checks++;
    if ({wb_valid_o, wb_we_o, wb_id_o, wb_rd_o, wb_data_o, busy_o, id_ready_o} !== {1'b0, 1'b0, 4'd0, 5'd0, 32'd0, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL reset_mid_mac: valid=%0b we=%0b id=%0h rd=%0h data=%08h busy=%0b ready=%0b, required 0 0 0 0 00000000 0 1",
               wb_valid_o, wb_we_o, wb_id_o, wb_rd_o, wb_data_o, busy_o, id_ready_o);
    end
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    model_reset();
    issue(OP_STSAM, 4'd1, 32'd0, 3'd0, 5'd4);
    get_resp(lat, id, rd, d, we);
    n_checks++;
    if (d !== 32'd0 || we !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_acc_clear: data=%08h we=%0b, required 00000000 1", d, we);
    end
    // Taps and delay line must also be clear: a new sample yields zero.
    issue(OP_LDSAM, 4'd2, 32'h0000_7FFF, 3'd0, 5'd0);
    model_ldsam(32767);
    get_resp(lat, id, rd, d, we);
    issue(OP_STSAM, 4'd3, 32'd0, 3'd0, 5'd4);
    get_resp(lat, id, rd, d, we);
    n_checks++;
    if (d !== 32'd0 || d !== model_stsam()) begin
      n_errors++;
      $display("FAIL reset_taps_clear: data=%08h, required 00000000", d);
    end
  endtask

  initial begin
    test_reset();
    test_tap_output();
    test_kill();
    test_kill_mismatch();
    test_backpressure();
    test_saturation();
    test_random();
    test_reset_mid_mac();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_xifu_ex.md
FIR_XIFU_EX -- requirements
Module: fir_xifu_ex

Interface
REQ-001 NTAPS, 8, number of FIR taps and delay-line depth (power of 2, 2..16).
REQ-002 ACC_W, 40, accumulator width in bits.
REQ-003 SHIFT, 15, right-shift applied to the accumulator for Q15 output.
REQ-004 clk_i  in  1  clock, rising edge; rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 id_valid_i  in  1  ID stage presents an instruction.
REQ-006 id_ready_o  out  1  EX accepts; transfer occurs when id_valid_i and id_ready_o are both high.
REQ-007 id_op_i  in  2  operation: NOP=0, LDTAP=1, LDSAM=2, STSAM=3.
REQ-008 id_instr_id_i  in  4  X-interface instruction id.
REQ-009 id_rs1_i  in  32  operand; bits [15:0] are the signed Q15 tap or sample.
REQ-010 id_tap_idx_i  in  log2(NTAPS)  tap index for LDTAP.
REQ-011 id_rd_i  in  5  destination register for STSAM.
REQ-012 kill_i  in  1  controller kills instruction kill_id_i; kill_id_i  in  4.
REQ-013 wb_valid_o  out  1; wb_ready_i  in  1  result handshake towards writeback.
REQ-014 wb_id_o  out  4; wb_rd_o  out  5; wb_data_o  out  32; wb_we_o  out  1  register-write enable.
REQ-015 busy_o  out  1  high whenever state is not IDLE.

Function
REQ-016 FSM states IDLE, MAC, RESP; id_ready_o is high only in IDLE.
REQ-017 NOP accepted in IDLE is dropped: no state change, no response.
REQ-018 LDTAP: tap[idx] <= rs1[15:0] on the accept edge; IDLE->RESP with wb_we_o=0, wb_data_o=0.
REQ-019 LDSAM: rs1[15:0] is captured into a staging register; IDLE->MAC; counter k runs 0..NTAPS-1, one signed 16x16 product per cycle.
REQ-020 MAC term k = tap[k]*x[k], where x[0]=staging and x[k]=dl[k-1]; products are sign-extended to ACC_W and summed into a fresh partial sum.
REQ-021 On the cycle k=NTAPS-1 completes: acc <= partial sum; delay line shifts (dl[0] <= staging, dl[i] <= dl[i-1]); MAC->RESP with wb_we_o=0. LDSAM accepted at edge T gives wb_valid_o high after edge T+NTAPS.
REQ-022 STSAM: IDLE->RESP with wb_we_o=1, wb_rd_o=id_rd_i, wb_data_o = sign-extension of sat16(acc >>> SHIFT); the shift is arithmetic.
REQ-023 sat16 clamps to 0x7FFF / 0xFFFF8000 on overflow of the signed 16-bit range.
REQ-024 RESP: wb_valid_o=1; wb_id_o, wb_rd_o, wb_data_o and wb_we_o stay stable until wb_ready_i; the handshake edge returns the FSM to IDLE.
REQ-025 kill_i with kill_id_i equal to the in-flight id is honoured in MAC only: the FSM goes to IDLE next edge, acc and the delay line are untouched, the staging value is discarded and no response is produced.
REQ-026 kill_i in IDLE or RESP, or with a non-matching id, has no effect.
REQ-027 Arithmetic wraps at ACC_W bits; no accumulator saturation.

Reset
REQ-028 Asynchronous reset, including mid-MAC, forces: state=IDLE, k=0, all taps, dl, staging and acc = 0.
REQ-029 Output values in reset: wb_valid_o=0, wb_we_o=0, wb_id_o=0, wb_rd_o=0, wb_data_o=0, busy_o=0, id_ready_o=1.

Structure
REQ-030 fir_xifu_pkg holds the op enum, NTAPS/ACC_W/SHIFT defaults, the fir_xifu_id2ex_t struct (valid, op, instr_id, rs1, tap_idx, rd) and the fir_xifu_ex2wb_t struct.
REQ-031 The multiply-accumulate datapath (signed multiplier, sign-extend, adder) lives in sub-module fir_xifu_mac; FSM, tap, delay-line and response registers live in fir_xifu_ex.

Verification
REQ-032 Tap write and output: LDTAP idx0=0x4000, then LDSAM 0x0100 -> response after 8 MAC cycles; then STSAM rd=5 -> wb_data_o=0x00000080, wb_we_o=1, wb_rd_o=5.
REQ-033 Saturation: all taps=0x7FFF, 8x LDSAM 0x7FFF, then STSAM -> wb_data_o=0x00007FFF; all samples 0x8000 instead -> wb_data_o=0xFFFF8000.
REQ-034 Backpressure: wb_ready_i low for 5 cycles in RESP -> wb_valid_o held, outputs stable, id_ready_o=0, then exactly one transfer.
REQ-035 Kill: LDSAM 0x1000 killed at MAC k=3 -> no response and busy_o low next cycle; following STSAM -> same value as before the kill (0x80 after REQ-032).
REQ-036 Reset mid-MAC -> all outputs at reset values; after release, STSAM -> wb_data_o=0.
REQ-037 Kill with a mismatched id during MAC -> ignored; normal response at T+NTAPS.
